// File: rtl/dcache_pkg.sv
// Shared DCache eviction-path types and geometry.
// Geometry defaults apply only when the build does not already define the DCACHE_* macros.
`ifndef DCACHE_MISS_WIDTH
`define DCACHE_MISS_WIDTH 4
`endif
`ifndef DCACHE_WAY
`define DCACHE_WAY 4
`endif
`ifndef DCACHE_SET_WIDTH
`define DCACHE_SET_WIDTH 6
`endif
`ifndef DCACHE_BANK
`define DCACHE_BANK 8
`endif
`ifndef DCACHE_BITS
`define DCACHE_BITS 64
`endif
`ifndef DCACHE_LINE
`define DCACHE_LINE 64
`endif
`ifndef VADDR_SIZE
`define VADDR_SIZE 39
`endif

package dcache_pkg;
  localparam int DCACHE_MISS_W  = `DCACHE_MISS_WIDTH;
  localparam int DCACHE_WAY_W   = $clog2(`DCACHE_WAY);
  localparam int DCACHE_SET_W   = `DCACHE_SET_WIDTH;
  localparam int DCACHE_BANK_N  = `DCACHE_BANK;
  localparam int DCACHE_BITS_N  = `DCACHE_BITS;
  localparam int DCACHE_LINE_OFF = $clog2(`DCACHE_LINE);
  localparam int DCACHE_VADDR_W = `VADDR_SIZE;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CAPT  = 3'd2,
    PUSH  = 3'd3,
    CLEAN = 3'd4
  } EvictState;

  typedef struct packed {
    logic [DCACHE_MISS_W-1:0]  missIdx;
    logic [DCACHE_VADDR_W-1:0] addr;
    logic [DCACHE_WAY_W-1:0]   way;
    logic                      dirty;
  } EvictReq;

  typedef logic [DCACHE_BANK_N-1:0][DCACHE_BITS_N-1:0] EvictLine;
endpackage

// File: rtl/dcache_evict_reader.sv
// Victim-eviction reader: reads dirty victim lines from the data banks and pushes them into the
// replace queue; clean victims are dropped with a one-cycle completion pulse.
// Optional macro DCACHE_EVICT_SKID_EN adds a one-entry request skid so a new request can be
// accepted while the FSM is busy and started the cycle it returns to IDLE.
module dcache_evict_reader
  import dcache_pkg::*;
#(
  parameter int MISS_W   = DCACHE_MISS_W,
  parameter int WAY_W    = DCACHE_WAY_W,
  parameter int SET_W    = DCACHE_SET_W,
  parameter int BANK     = DCACHE_BANK_N,
  parameter int BITS     = DCACHE_BITS_N,
  parameter int LINE_OFF = DCACHE_LINE_OFF,
  parameter int VADDR_W  = DCACHE_VADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [MISS_W-1:0]      req_miss_idx,
  input  logic [VADDR_W-1:0]     req_addr,
  input  logic [WAY_W-1:0]       req_way,
  input  logic                   req_dirty,
  output logic                   rd_req,
  input  logic                   rd_grant,
  output logic [SET_W-1:0]       rd_set,
  output logic [WAY_W-1:0]       rd_way,
  input  logic [BANK*BITS-1:0]   rd_data,
  output logic                   rq_en,
  input  logic                   rq_full,
  output logic [MISS_W-1:0]      rq_miss_idx,
  output logic [VADDR_W-1:0]     rq_addr,
  output logic [BANK*BITS-1:0]   rq_data,
  output logic                   clean_done,
  output logic [MISS_W-1:0]      clean_idx
);
  localparam int LINE_W = BANK * BITS;
  localparam int TAG_W  = VADDR_W - LINE_OFF;

  EvictState state, state_nxt;

  // Launched request; only the line-aligned address bits are kept
  logic [MISS_W-1:0] idx_p0;
  logic [TAG_W-1:0]  addr_p0;
  logic [WAY_W-1:0]  way_p0;
  logic [LINE_W-1:0] line_p1;

  logic              start;
  logic [MISS_W-1:0] src_idx;
  logic [TAG_W-1:0]  src_addr;
  logic [WAY_W-1:0]  src_way;
  logic              src_dirty;

  // Byte-offset bits of the victim address carry no information for a line eviction
  logic unused_addr_off;
  assign unused_addr_off = ^req_addr[LINE_OFF-1:0];

`ifdef DCACHE_EVICT_SKID_EN
  logic              skid_valid;
  logic [MISS_W-1:0] skid_idx;
  logic [TAG_W-1:0]  skid_addr;
  logic [WAY_W-1:0]  skid_way;
  logic              skid_dirty;
  logic              acc;

  assign req_ready = ~skid_valid & ~rst;
  assign acc       = req_valid & req_ready;
  // A parked request has priority; a fresh one bypasses the skid when the FSM is free
  assign start     = (state == IDLE) & (skid_valid | acc);
  assign src_idx   = skid_valid ? skid_idx   : req_miss_idx;
  assign src_addr  = skid_valid ? skid_addr  : req_addr[VADDR_W-1:LINE_OFF];
  assign src_way   = skid_valid ? skid_way   : req_way;
  assign src_dirty = skid_valid ? skid_dirty : req_dirty;

  // Skid occupancy: filled when accepting while busy, drained when the FSM launches it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      skid_valid <= 1'b0;
    else if (acc && state != IDLE)
      skid_valid <= 1'b1;
    else if (start && skid_valid)
      skid_valid <= 1'b0;
  end

  // Skid payload, loaded alongside the occupancy bit
  always_ff @(posedge clk) begin
    if (acc && state != IDLE) begin
      skid_idx   <= req_miss_idx;
      skid_addr  <= req_addr[VADDR_W-1:LINE_OFF];
      skid_way   <= req_way;
      skid_dirty <= req_dirty;
    end
  end
`else
  assign req_ready = (state == IDLE) & ~rst;
  assign start     = req_valid & req_ready;
  assign src_idx   = req_miss_idx;
  assign src_addr  = req_addr[VADDR_W-1:LINE_OFF];
  assign src_way   = req_way;
  assign src_dirty = req_dirty;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = src_dirty ? READ : CLEAN;
      READ:    if (rd_grant) state_nxt = CAPT;
      CAPT:    state_nxt = PUSH;
      PUSH:    if (!rq_full) state_nxt = IDLE;
      CLEAN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: request latched at launch, held for the whole operation
  always_ff @(posedge clk) begin
    if (start) begin
      idx_p0  <= src_idx;
      addr_p0 <= src_addr;
      way_p0  <= src_way;
    end
  end

  // Stage p1: bank data is valid only in the cycle after the grant
  always_ff @(posedge clk) begin
    if (state == CAPT) line_p1 <= rd_data;
  end

  // Outputs are gated by state so a reset clears them immediately and no stale data leaks
  always_comb begin
    rd_req      = 1'b0;
    rd_set      = '0;
    rd_way      = '0;
    rq_en       = 1'b0;
    rq_miss_idx = '0;
    rq_addr     = '0;
    rq_data     = '0;
    clean_done  = 1'b0;
    clean_idx   = '0;
    case (state)
      READ: begin
        rd_req = 1'b1;
        rd_set = addr_p0[SET_W-1:0];
        rd_way = way_p0;
      end
      PUSH: begin
        rq_en       = 1'b1;
        rq_miss_idx = idx_p0;
        rq_addr     = {addr_p0, {LINE_OFF{1'b0}}};
        rq_data     = line_p1;
      end
      CLEAN: begin
        clean_done = 1'b1;
        clean_idx  = idx_p0;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_dcache_evict_reader.sv
// Testbench for dcache_evict_reader: directed scenarios plus randomized traffic against a
// transaction-level model (expected pushes / clean completions kept in queues).
module tb_dcache_evict_reader;
  import dcache_pkg::*;

  localparam int MISS_W   = DCACHE_MISS_W;
  localparam int WAY_W    = DCACHE_WAY_W;
  localparam int SET_W    = DCACHE_SET_W;
  localparam int LINE_OFF = DCACHE_LINE_OFF;
  localparam int VA_W     = DCACHE_VADDR_W;
  localparam int LINE_W   = DCACHE_BANK_N * DCACHE_BITS_N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_ready, req_dirty = 1'b0;
  logic [MISS_W-1:0] req_miss_idx = '0;
  logic [VA_W-1:0] req_addr = '0;
  logic [WAY_W-1:0] req_way = '0;
  logic rd_req, rd_grant = 1'b0;
  logic [SET_W-1:0] rd_set;
  logic [WAY_W-1:0] rd_way;
  logic [LINE_W-1:0] rd_data = '0;
  logic rq_en, rq_full = 1'b0;
  logic [MISS_W-1:0] rq_miss_idx, clean_idx;
  logic [VA_W-1:0] rq_addr;
  logic [LINE_W-1:0] rq_data;
  logic clean_done;

  always #5 clk = ~clk;

  dcache_evict_reader dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_miss_idx(req_miss_idx),
    .req_addr(req_addr), .req_way(req_way), .req_dirty(req_dirty),
    .rd_req(rd_req), .rd_grant(rd_grant), .rd_set(rd_set), .rd_way(rd_way), .rd_data(rd_data),
    .rq_en(rq_en), .rq_full(rq_full), .rq_miss_idx(rq_miss_idx), .rq_addr(rq_addr),
    .rq_data(rq_data), .clean_done(clean_done), .clean_idx(clean_idx)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  EvictReq dq[$];
  logic [MISS_W-1:0] cq[$];
  logic [LINE_W-1:0] lq[$];
  logic grant_seen = 1'b0;
  int cyc = 0;
  int push_cnt = 0, clean_cnt = 0, acc_cnt = 0;
  int rd_req_cyc = 0, rq_en_cyc = 0, clean_cyc = 0;
  int last_acc = 0, last_push = 0, prev_push = 0, last_clean = 0;
  logic [VA_W-1:0] last_push_addr = '0;
  logic [SET_W-1:0] last_rd_set = '0;
  EvictReq hd;
  logic [VA_W-1:0] exp_addr;
  logic grant_rand = 1'b0, full_rand = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      dq.delete(); cq.delete(); lq.delete();
      grant_seen = 1'b0;
    end else begin
      if (grant_seen) lq.push_back(rd_data);
      grant_seen = rd_req && rd_grant;
      if (rd_req) begin
        rd_req_cyc++;
        last_rd_set = rd_set;
        check("rd_has_req", dq.size() > 0, 1'b1);
        if (dq.size() > 0) begin
          check("rd_set", rd_set, dq[0].addr[LINE_OFF +: SET_W]);
          check("rd_way", rd_way, dq[0].way);
        end
      end
      if (rq_en) begin
        rq_en_cyc++;
        check("push_has_req", (dq.size() > 0) && (lq.size() > 0), 1'b1);
        if (dq.size() > 0 && lq.size() > 0) begin
          exp_addr = dq[0].addr;
          exp_addr[LINE_OFF-1:0] = '0;
          check("rq_idx", rq_miss_idx, dq[0].missIdx);
          check("rq_addr", rq_addr, exp_addr);
          check("rq_data", rq_data, lq[0]);
          if (!rq_full) begin
            hd = dq.pop_front();
            void'(lq.pop_front());
            prev_push = last_push;
            last_push = cyc;
            last_push_addr = rq_addr;
            push_cnt++;
          end
        end
      end
      if (clean_done) begin
        clean_cyc++;
        check("clean_has_req", cq.size() > 0, 1'b1);
        if (cq.size() > 0) begin
          check("clean_idx", clean_idx, cq.pop_front());
          last_clean = cyc;
          clean_cnt++;
        end
      end
      if (req_valid && req_ready) begin
        if (req_dirty) dq.push_back('{missIdx: req_miss_idx, addr: req_addr, way: req_way, dirty: 1'b1});
        else cq.push_back(req_miss_idx);
        acc_cnt++;
        last_acc = cyc;
      end
    end
  end

  // Background stimulus: fresh bank data every cycle, optional random grant / backpressure
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < LINE_W / 32; i++) rd_data[i*32 +: 32] = $urandom;
    if (grant_rand) rd_grant = ($urandom_range(0, 2) == 0);
    if (full_rand) rq_full = ($urandom_range(0, 3) == 0);
  end

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [MISS_W-1:0] idx, input logic [VA_W-1:0] a,
                      input logic [WAY_W-1:0] w, input logic d);
    int n;
    n = 0;
    req_valid = 1'b1; req_miss_idx = idx; req_addr = a; req_way = w; req_dirty = d;
    while (!req_ready && n < 100) begin tick(1); n++; end
    if (!req_ready) check("ready_timeout", req_ready, 1'b1);
    tick(1);
    req_valid = 1'b0;
  endtask

  task automatic wait_push(input int target);
    int n;
    n = 0;
    while (push_cnt < target && n < 200) begin tick(1); n++; end
    if (push_cnt < target) check("push_timeout", push_cnt >= target, 1'b1);
  endtask

  task automatic wait_clean(input int target);
    int n;
    n = 0;
    while (clean_cnt < target && n < 200) begin tick(1); n++; end
    if (clean_cnt < target) check("clean_timeout", clean_cnt >= target, 1'b1);
  endtask

  int p0, r0, e0, c0, cl0, a0;
  logic [63:0] r64;

  initial begin
    // Reset state
    tick(2);
    @(negedge clk);
    check("rst_ready", req_ready, 1'b0);
    check("rst_outs", {rd_req, rq_en, clean_done}, 3'b000);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("ready_after_rst", req_ready, 1'b1);
    tick(1);

    // 1: dirty request, immediate grant
    rd_grant = 1'b1; rq_full = 1'b0;
    p0 = push_cnt; e0 = rq_en_cyc;
    send(4'd2, 39'h0_8000_1234, 2'd3, 1'b1);
    wait_push(p0 + 1);
    tick(1);
    check("t1_latency", last_push - last_acc, 3);
    check("t1_rd_set", last_rd_set, 6'h08);
    check("t1_rq_addr", last_push_addr, 39'h0_8000_1200);
    check("t1_rq_en_cycles", rq_en_cyc - e0, 1);

    // 2: clean request
    r0 = rd_req_cyc; e0 = rq_en_cyc; c0 = clean_cnt; cl0 = clean_cyc;
    send(4'd1, 39'h0_1234_5678, 2'd1, 1'b0);
    wait_clean(c0 + 1);
    tick(2);
    check("t2_clean_latency", last_clean - last_acc, 1);
    check("t2_clean_cycles", clean_cyc - cl0, 1);
    check("t2_no_rd_req", rd_req_cyc - r0, 0);
    check("t2_no_rq_en", rq_en_cyc - e0, 0);

    // 3: grant withheld five cycles
    rd_grant = 1'b0;
    r0 = rd_req_cyc; p0 = push_cnt;
    send(4'd5, 39'h0_0ABC_DEC0, 2'd2, 1'b1);
    tick(5);
    rd_grant = 1'b1;
    wait_push(p0 + 1);
    check("t3_rd_req_cycles", rd_req_cyc - r0, 6);

    // 4: replace queue full four cycles in PUSH
    tick(1);
    rq_full = 1'b1;
    p0 = push_cnt; e0 = rq_en_cyc;
    send(4'd7, 39'h7_FFFF_FFC3, 2'd0, 1'b1);
    begin
      int n;
      n = 0;
      while (!rq_en && n < 20) begin tick(1); n++; end
    end
    tick(4);
    check("t4_not_pushed_yet", push_cnt - p0, 0);
    rq_full = 1'b0;
    tick(3);
    check("t4_rq_en_cycles", rq_en_cyc - e0, 5);
    check("t4_one_enqueue", push_cnt - p0, 1);

    // 5: reset while capturing
    p0 = push_cnt;
    send(4'd9, 39'h0_4444_4440, 2'd1, 1'b1);
    tick(1);
    rst = 1'b1;
    #1;
    check("t5_outs_zero", {rd_req, rq_en, clean_done, req_ready}, 4'b0000);
    check("t5_rq_data_zero", rq_data, '0);
    tick(1);
    rst = 1'b0;
    tick(4);
    check("t5_no_stale_push", push_cnt - p0, 0);
    send(4'd3, 39'h0_5555_5580, 2'd2, 1'b1);
    wait_push(p0 + 1);
    tick(2);
    check("t5_single_push", push_cnt - p0, 1);

    // 6: two dirty requests back to back
    p0 = push_cnt; a0 = acc_cnt;
    send(4'd4, 39'h0_1000_0040, 2'd1, 1'b1);
    a0 = last_acc;
`ifdef DCACHE_EVICT_SKID_EN
    check("t6_ready_busy", req_ready, 1'b1);
`endif
    send(4'd6, 39'h0_2000_0080, 2'd2, 1'b1);
`ifdef DCACHE_EVICT_SKID_EN
    check("t6_accept_gap", last_acc - a0, 1);
`else
    check("t6_accept_gap", last_acc - a0, 4);
`endif
    wait_push(p0 + 2);
    check("t6_push_gap", last_push - prev_push, 4);

    // Randomized traffic
    tick(2);
    grant_rand = 1'b1; full_rand = 1'b1;
    p0 = push_cnt; c0 = clean_cnt; a0 = acc_cnt;
    for (int i = 0; i < 200; i++) begin
      tick($urandom_range(0, 2));
      r64 = {$urandom, $urandom};
      send(MISS_W'($urandom), r64[VA_W-1:0], WAY_W'($urandom), 1'($urandom));
    end
    grant_rand = 1'b0; full_rand = 1'b0;
    rd_grant = 1'b1; rq_full = 1'b0;
    tick(20);
    check("rand_dq_drained", dq.size(), 0);
    check("rand_cq_drained", cq.size(), 0);
    check("rand_all_done", (push_cnt - p0) + (clean_cnt - c0), acc_cnt - a0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
